// File: rtl/bypass_rd_rsp_scheduler_pkg.sv
// Shared constants and the read-command descriptor for the bypass read-response scheduler.
package bypass_rd_rsp_scheduler_pkg;

  localparam int AXI_NET_BITS = 64;
  localparam int N_REGIONS    = 4;
  localparam int VFID_BITS    = 4;

  // Read command from the network stack; vfid selects the owning region.
  typedef struct packed {
    logic [VFID_BITS-1:0] vfid;
    logic [5:0]           pid;
    logic [31:0]          vaddr;
    logic [19:0]          len;
    logic                 last;
  } req_t;

endpackage

// File: rtl/bypass_vfid_fifo.sv
// Order FIFO remembering which region owns each outstanding read response.
// The head is a register, so an entry becomes visible the cycle after its push.
module bypass_vfid_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   head_valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             head_valid_reg;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && head_valid_reg;

  // Next head: the entry behind the (possibly advanced) read pointer, or the
  // word being written this cycle when it lands exactly at the new head.
  always_comb begin
    rd_ptr_next = rd_ptr_reg + PW'(pop_ok);
    count_next  = count_reg + CW'(push_ok) - CW'(pop_ok);
    head_next   = mem[rd_ptr_next];
    if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
      head_next = push_data;
    end
  end

  // Storage array; contents need no reset since occupancy guards every read.
  always_ff @(posedge aclk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      head_reg       <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_reg + PW'(push_ok);
      count_reg      <= count_next;
      head_reg       <= head_next;
      head_valid_reg <= (count_next != '0);
    end
  end

  assign head       = head_reg;
  assign head_valid = head_valid_reg;
  assign count      = count_reg;

endmodule

// File: rtl/bypass_rd_rsp_scheduler.sv
// Dispatches bypass read commands to their region and merges the per-region
// read responses back in command order, with zero added latency on both paths.
module bypass_rd_rsp_scheduler
  import bypass_rd_rsp_scheduler_pkg::*;
#(
  parameter int N_REGIONS   = bypass_rd_rsp_scheduler_pkg::N_REGIONS,
  parameter int ORDER_DEPTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      s_bypass_rq_rd_valid,
  output logic                      s_bypass_rq_rd_ready,
  input  req_t                      s_bypass_rq_rd_data,
  output logic [N_REGIONS-1:0]      m_bypass_rq_rd_valid,
  input  logic [N_REGIONS-1:0]      m_bypass_rq_rd_ready,
  output req_t                      m_bypass_rq_rd_data [N_REGIONS],
  input  logic [N_REGIONS-1:0]      s_axis_rd_rsp_tvalid,
  output logic [N_REGIONS-1:0]      s_axis_rd_rsp_tready,
  input  logic [AXI_NET_BITS-1:0]   s_axis_rd_rsp_tdata [N_REGIONS],
  input  logic [AXI_NET_BITS/8-1:0] s_axis_rd_rsp_tkeep [N_REGIONS],
  input  logic [N_REGIONS-1:0]      s_axis_rd_rsp_tlast,
  output logic                      m_axis_rd_rsp_tvalid,
  input  logic                      m_axis_rd_rsp_tready,
  output logic [AXI_NET_BITS-1:0]   m_axis_rd_rsp_tdata,
  output logic [AXI_NET_BITS/8-1:0] m_axis_rd_rsp_tkeep,
  output logic                      m_axis_rd_rsp_tlast,
  output logic [$clog2(ORDER_DEPTH):0] order_occ,
  output logic [31:0]               err_cnt,
  output logic [15:0]               beat_cnt
);

  localparam int RB = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  logic [VFID_BITS-1:0]  cmd_vfid;
  logic                  cmd_in_range, tgt_ready, cmd_fire, push, fifo_full;
  logic [RB-1:0]         head;
  logic                  head_valid, rsp_active, beat, pop;
  logic                  sel_tvalid, sel_tlast;
  logic [AXI_NET_BITS-1:0]   sel_tdata;
  logic [AXI_NET_BITS/8-1:0] sel_tkeep;
  logic [31:0]           err_cnt_reg;
  logic [15:0]           beat_cnt_reg;

  assign cmd_vfid     = s_bypass_rq_rd_data.vfid;
  assign cmd_in_range = (32'(cmd_vfid) < 32'(N_REGIONS));

  // Ready of the addressed region; out-of-range commands are simply swallowed.
  always_comb begin
    tgt_ready = !cmd_in_range;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (cmd_vfid == VFID_BITS'(i)) begin
        tgt_ready = m_bypass_rq_rd_ready[i];
      end
    end
  end

  // A full order FIFO blocks dispatch even when a pop happens the same cycle.
  assign s_bypass_rq_rd_ready = aresetn && !fifo_full && tgt_ready;
  assign cmd_fire             = s_bypass_rq_rd_valid && s_bypass_rq_rd_ready;
  assign push                 = cmd_fire && cmd_in_range;

  generate
    for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_dispatch
      assign m_bypass_rq_rd_valid[gi] = aresetn && s_bypass_rq_rd_valid && !fifo_full &&
                                        (cmd_vfid == VFID_BITS'(gi));
      assign m_bypass_rq_rd_data[gi]  = s_bypass_rq_rd_data;
    end
  endgenerate

  bypass_vfid_fifo #(
    .DEPTH (ORDER_DEPTH),
    .WIDTH (RB)
  ) u_order_fifo (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .push       (push),
    .push_data  (RB'(cmd_vfid)),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .full       (fifo_full),
    .count      (order_occ)
  );

  assign rsp_active = aresetn && head_valid;

  // Response mux: forward the beat of the region at the head of the order FIFO.
  always_comb begin
    sel_tvalid = 1'b0;
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tlast  = 1'b0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (head == RB'(i)) begin
        sel_tvalid = s_axis_rd_rsp_tvalid[i];
        sel_tdata  = s_axis_rd_rsp_tdata[i];
        sel_tkeep  = s_axis_rd_rsp_tkeep[i];
        sel_tlast  = s_axis_rd_rsp_tlast[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_rsp_ready
      assign s_axis_rd_rsp_tready[gi] = rsp_active && (head == RB'(gi)) && m_axis_rd_rsp_tready;
    end
  endgenerate

  assign m_axis_rd_rsp_tvalid = rsp_active && sel_tvalid;
  assign m_axis_rd_rsp_tdata  = sel_tdata;
  assign m_axis_rd_rsp_tkeep  = sel_tkeep;
  assign m_axis_rd_rsp_tlast  = sel_tlast;

  assign beat = m_axis_rd_rsp_tvalid && m_axis_rd_rsp_tready;
  assign pop  = beat && sel_tlast;

  // Discarded-command counter (saturating) and beat position within the response.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
    end else begin
      if (cmd_fire && !cmd_in_range && (err_cnt_reg != 32'hFFFF_FFFF)) begin
        err_cnt_reg <= err_cnt_reg + 32'd1;
      end
      if (pop) begin
        beat_cnt_reg <= '0;
      end else if (beat) begin
        beat_cnt_reg <= beat_cnt_reg + 16'd1;
      end
    end
  end

  assign err_cnt  = err_cnt_reg;
  assign beat_cnt = beat_cnt_reg;

endmodule
